// File: rtl/kmeans_pkg.sv
// kmeans_pkg
// Shared constants and types for the k-means mean update path.
//   PIX_W  : width of one packed RGB mean (3 x 8 bits)
//   CH_W   : width of one colour channel of a mean
//   ACC_W  : width of one cluster's packed channel sums (3 x 24 bits)
//   CNT_W  : width of one cluster's pixel counter
//   N_CH   : number of colour channels
//   stateType : sequencing states of mean_update_engine
//   satByte   : clamps a wide quotient to an 8-bit channel value
package kmeans_pkg;

   localparam int PIX_W = 24;
   localparam int CH_W  = 8;
   localparam int ACC_W = 72;
   localparam int CNT_W = 12;
   localparam int N_CH  = 3;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SELECT,
      DIV,
      DONE
   } stateType;

   // A channel mean can only exceed 255 when the sums and counters
   // disagree (e.g. corrupted or synthetic inputs), so anything wider
   // than a byte is pinned to full scale rather than wrapped.
   function automatic logic [CH_W-1:0] satByte(input logic [PIX_W-1:0] q);
      return (|q[PIX_W-1:CH_W]) ? {CH_W{1'b1}} : q[CH_W-1:0];
   endfunction

endpackage

// File: rtl/serial_divider.sv
// serial_divider
// Restoring unsigned divider producing one quotient bit per cycle.
// A division takes exactly DIV_W cycles, the first of them being the
// cycle in which i_start is high, so back-to-back divisions can be
// issued with no idle cycle between them.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   i_start       : begin a division using i_dividend / i_divisor
//   i_dividend    : DIV_W-bit dividend (sampled only with i_start)
//   i_divisor     : DVS_W-bit divisor, must be nonzero
//   o_busy        : a division is in progress past its first cycle
//   o_valid       : this cycle performs the final iteration; o_quotient
//                   and o_remainder carry the finished result now
//   o_quotient    : quotient (final when o_valid)
//   o_remainder   : remainder (final when o_valid)
module serial_divider
   import kmeans_pkg::*;
#(
   parameter int DIV_W = PIX_W,
   parameter int DVS_W = CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic [DIV_W-1:0] i_dividend,
   input  logic [DVS_W-1:0] i_divisor,
   output logic             o_busy,
   output logic             o_valid,
   output logic [DIV_W-1:0] o_quotient,
   output logic [DVS_W-1:0] o_remainder
);

   localparam int CW = (DIV_W > 1) ? $clog2(DIV_W) : 1;

   logic [DVS_W-1:0] r_rem;
   logic [DIV_W-1:0] r_quo;
   logic [DVS_W-1:0] r_divisor;
   logic [CW-1:0]    r_iter;
   logic             r_busy;

   logic             w_active;
   logic [DVS_W-1:0] w_remSrc;
   logic [DIV_W-1:0] w_quoSrc;
   logic [DVS_W-1:0] w_dvs;
   logic [CW-1:0]    w_iter;
   logic [DVS_W:0]   w_shift;
   logic [DVS_W:0]   w_diff;
   logic             w_ge;
   logic [DVS_W-1:0] w_remNext;
   logic [DIV_W-1:0] w_quoNext;
   logic             w_last;

   // One restoring step. On the start cycle the step works straight from
   // the input operands so the first quotient bit is produced immediately;
   // afterwards it works from the registered partial results. The quotient
   // register doubles as the dividend shift register.
   always_comb begin
      w_active  = i_start | r_busy;
      w_remSrc  = i_start ? '0 : r_rem;
      w_quoSrc  = i_start ? i_dividend : r_quo;
      w_dvs     = i_start ? i_divisor : r_divisor;
      w_iter    = i_start ? '0 : r_iter;
      w_shift   = {w_remSrc, w_quoSrc[DIV_W-1]};
      w_diff    = w_shift - {1'b0, w_dvs};
      w_ge      = (w_shift >= {1'b0, w_dvs});
      w_remNext = w_ge ? w_diff[DVS_W-1:0] : w_shift[DVS_W-1:0];
      w_quoNext = {w_quoSrc[DIV_W-2:0], w_ge};
      w_last    = w_active && (w_iter == CW'(DIV_W-1));
   end

   // Partial remainder/quotient registers and the iteration counter. The
   // divider goes idle on the same edge that retires the final step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rem     <= '0;
         r_quo     <= '0;
         r_divisor <= '0;
         r_iter    <= '0;
         r_busy    <= 1'b0;
      end else if (w_active) begin
         r_rem  <= w_remNext;
         r_quo  <= w_quoNext;
         r_iter <= w_last ? '0 : w_iter + 1'b1;
         r_busy <= !w_last;
         if (i_start) begin
            r_divisor <= i_divisor;
         end
      end
   end

   assign o_busy      = r_busy;
   assign o_valid     = w_last;
   assign o_quotient  = w_quoNext;
   assign o_remainder = w_remNext;

endmodule

// File: rtl/mean_update_engine.sv
// mean_update_engine
// Turns the per-cluster channel sums and pixel counters gathered by
// cluster_engine into new cluster means, one serial division per channel,
// and holds the live mean set that is fed back to cluster_engine.
// Build option: define MEAN_ROUND_EN for round-half-up means (the
// dividend becomes sum + count/2); without it the means are truncated.
// Either way the pass latency is the same.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   start          : pulse in IDLE to snapshot inputs and run a pass
//   enabled        : per-cluster enable mask (0 = keep old mean)
//   accumolatorIn  : per-cluster 3 x 24-bit channel sums
//   countersIn     : per-cluster 12-bit pixel counts
//   seedLoad       : in IDLE, load meanOut from seedMean (beats start)
//   seedMean       : initial means, 24 bits per cluster
//   meanOut        : current means, 24 bits per cluster
//   busy           : a pass is in progress (LOAD through DONE)
//   done           : one-cycle pulse, meanOut has just been updated
//   converged      : the last pass changed no mean
module mean_update_engine
   import kmeans_pkg::*;
#(
   parameter int T     = 16,
   parameter int DIV_W = 24
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [T-1:0]         enabled,
   input  logic [ACC_W*T-1:0]   accumolatorIn,
   input  logic [CNT_W*T-1:0]   countersIn,
   input  logic                 seedLoad,
   input  logic [PIX_W*T-1:0]   seedMean,
   output logic [PIX_W*T-1:0]   meanOut,
   output logic                 busy,
   output logic                 done,
   output logic                 converged
);

   localparam int KW    = (T > 1) ? $clog2(T) : 1;
   localparam int SUM_W = ACC_W / N_CH;

   stateType r_state;
   stateType w_nextState;

   logic [KW-1:0]        r_k;
   logic [1:0]           r_c;
   logic [ACC_W*T-1:0]   r_acc;
   logic [CNT_W*T-1:0]   r_count;
   logic [T-1:0]         r_en;
   logic [PIX_W*T-1:0]   r_newMean;
   logic [PIX_W*T-1:0]   r_meanOut;
   logic                 r_converged;
   logic                 r_done;

   logic [SUM_W-1:0]     w_sum;
   logic [CNT_W-1:0]     w_cnt;
   logic                 w_skip;
   logic                 w_lastK;
   logic [DIV_W-1:0]     w_dividend;
   logic                 w_divStart;
   logic                 w_divBusy;
   logic                 w_divValid;
   logic [DIV_W-1:0]     w_divQuo;
   logic [CNT_W-1:0]     w_divRemUnused;
   logic [CH_W-1:0]      w_byte;
`ifdef MEAN_ROUND_EN
   logic [SUM_W:0]       w_rounded;
`endif

   // Operand selection for the cluster/channel currently being worked on.
   // A cluster with no pixels would divide by zero, so it is treated the
   // same as a disabled cluster and simply keeps its previous mean.
   always_comb begin
      w_sum   = r_acc[r_k*ACC_W + r_c*SUM_W +: SUM_W];
      w_cnt   = r_count[r_k*CNT_W +: CNT_W];
      w_skip  = !r_en[r_k] || (w_cnt == '0);
      w_lastK = (r_k == KW'(T-1));
`ifdef MEAN_ROUND_EN
      w_rounded  = {1'b0, w_sum} + (SUM_W+1)'(w_cnt >> 1);
      w_dividend = w_rounded[SUM_W] ? '1 : DIV_W'(w_rounded[SUM_W-1:0]);
`else
      w_dividend = DIV_W'(w_sum);
`endif
      w_byte     = satByte(PIX_W'(w_divQuo));
      w_divStart = (r_state == DIV) && !w_divBusy;
   end

   // The divider is restarted on the first DIV cycle of every channel; it
   // reports valid on its last iteration so the result lands in newMean on
   // that same edge and the next channel can start right away.
   serial_divider #(
      .DIV_W (DIV_W),
      .DVS_W (CNT_W)
   ) u_divider (
      .clk         (clk),
      .reset       (reset),
      .i_start     (w_divStart),
      .i_dividend  (w_dividend),
      .i_divisor   (w_cnt),
      .o_busy      (w_divBusy),
      .o_valid     (w_divValid),
      .o_quotient  (w_divQuo),
      .o_remainder (w_divRemUnused)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. A seed load in IDLE takes priority over start, and
   // start is ignored in every other state because only IDLE looks at it.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (!seedLoad && start) begin
               w_nextState = LOAD;
            end
         end
         LOAD: begin
            w_nextState = SELECT;
         end
         SELECT: begin
            if (w_skip) begin
               w_nextState = w_lastK ? DONE : SELECT;
            end else begin
               w_nextState = DIV;
            end
         end
         DIV: begin
            if (w_divValid && (r_c == 2'd2)) begin
               w_nextState = w_lastK ? DONE : SELECT;
            end
         end
         DONE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Datapath. Inputs are snapshotted in LOAD so later changes cannot
   // disturb the pass, and all results collect in newMean so meanOut only
   // changes once, atomically, in DONE. Reset discards any partial pass.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_k         <= '0;
         r_c         <= '0;
         r_acc       <= '0;
         r_count     <= '0;
         r_en        <= '0;
         r_newMean   <= '0;
         r_meanOut   <= '0;
         r_converged <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= (r_state == DONE);
         case (r_state)
            IDLE: begin
               if (seedLoad) begin
                  r_meanOut   <= seedMean;
                  r_converged <= 1'b0;
               end
            end
            LOAD: begin
               r_acc     <= accumolatorIn;
               r_count   <= countersIn;
               r_en      <= enabled;
               r_newMean <= r_meanOut;
               r_k       <= '0;
               r_c       <= '0;
            end
            SELECT: begin
               r_c <= '0;
               if (w_skip && !w_lastK) begin
                  r_k <= r_k + 1'b1;
               end
            end
            DIV: begin
               if (w_divValid) begin
                  r_newMean[r_k*PIX_W + r_c*CH_W +: CH_W] <= w_byte;
                  if (r_c == 2'd2) begin
                     r_c <= '0;
                     if (!w_lastK) begin
                        r_k <= r_k + 1'b1;
                     end
                  end else begin
                     r_c <= r_c + 1'b1;
                  end
               end
            end
            DONE: begin
               r_meanOut   <= r_newMean;
               r_converged <= (r_newMean == r_meanOut);
            end
            default: begin
            end
         endcase
      end
   end

   assign meanOut   = r_meanOut;
   assign busy      = (r_state != IDLE);
   assign done      = r_done;
   assign converged = r_converged;

endmodule

// File: tb/tb_mean_update_engine.sv
// tb_mean_update_engine
// Self-checking bench for mean_update_engine. Expected means, latency and
// convergence come from a plain arithmetic model of the mean rules.
// Honours MEAN_ROUND_EN when it is defined for the build.
module tb_mean_update_engine;

   localparam int T     = 16;
   localparam int DIV_W = 24;
   localparam int MW    = 24 * T;

   logic            clk;
   logic            reset;
   logic            start;
   logic [T-1:0]    enabled;
   logic [72*T-1:0] accumolatorIn;
   logic [12*T-1:0] countersIn;
   logic            seedLoad;
   logic [MW-1:0]   seedMean;
   logic [MW-1:0]   meanOut;
   logic            busy;
   logic            done;
   logic            converged;

   int              testsRun;
   int              failCount;
   logic [MW-1:0]   modelMean;

   mean_update_engine #(
      .T     (T),
      .DIV_W (DIV_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .enabled       (enabled),
      .accumolatorIn (accumolatorIn),
      .countersIn    (countersIn),
      .seedLoad      (seedLoad),
      .seedMean      (seedMean),
      .meanOut       (meanOut),
      .busy          (busy),
      .done          (done),
      .converged     (converged)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single comparison point: counts the check and reports any miss.
   task automatic checkOutput(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
      testsRun++;
      assert (obs === exp)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: mean per channel = sum / count (optionally rounded
   // half-up, dividend capped at 24 bits), clamped to 255; clusters that
   // are disabled or empty keep their old mean. n = clusters divided.
   function automatic logic [MW-1:0] refMeans(input logic [MW-1:0] old, input logic [T-1:0] e,
                                              input logic [72*T-1:0] a, input logic [12*T-1:0] c,
                                              output int n);
      logic [MW-1:0] res;
      longint s;
      longint d;
      longint q;
      res = old;
      n = 0;
      for (int k = 0; k < T; k++) begin
         d = longint'(c[k*12 +: 12]);
         if (e[k] && d != 0) begin
            n++;
            for (int ch = 0; ch < 3; ch++) begin
               s = longint'(a[k*72 + ch*24 +: 24]);
`ifdef MEAN_ROUND_EN
               s = s + d / 2;
               if (s > 64'hFF_FFFF) s = 64'hFF_FFFF;
`endif
               q = s / d;
               if (q > 255) q = 255;
               res[k*24 + ch*8 +: 8] = q[7:0];
            end
         end
      end
      return res;
   endfunction

   // Random pass inputs. Tame sums look like real pixel data (mean <= 255);
   // wild sums are arbitrary 24-bit values that often saturate.
   task automatic applyStimulus(input bit wild);
      int unsigned c;
      int unsigned s;
      for (int k = 0; k < T; k++) begin
         enabled[k] = ($urandom_range(0, 3) != 0);
         c = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 4095);
         countersIn[k*12 +: 12] = c[11:0];
         for (int ch = 0; ch < 3; ch++) begin
            if (wild) s = $urandom_range(0, 32'h00FF_FFFF);
            else if (c == 0) s = 0;
            else s = c * $urandom_range(0, 255) + $urandom_range(0, c - 1);
            accumolatorIn[k*72 + ch*24 +: 24] = s[23:0];
         end
      end
   endtask

   // Random set of seed means.
   task automatic randomSeed(output logic [MW-1:0] v);
      for (int i = 0; i < MW; i += 32) v[i +: 32] = $urandom;
   endtask

   // Load seed means from IDLE.
   task automatic loadSeed(input logic [MW-1:0] v);
      seedMean = v;
      seedLoad = 1'b1;
      tick();
      seedLoad = 1'b0;
      modelMean = v;
      checkOutput("seed meanOut", meanOut, v);
      checkOutput("seed converged", MW'(converged), '0);
   endtask

   // One complete pass with checks on latency, results, convergence, mean
   // stability during the pass and a single done pulse. With chaos set the
   // inputs are scrambled after LOAD and start+seedLoad are pulsed mid-pass.
   task automatic runPass(input string tag, input bit chaos);
      logic [MW-1:0] oldMean;
      logic [MW-1:0] expMean;
      logic [MW-1:0] junk;
      int n;
      int expLat;
      int cycles;
      int extraDone;
      bit stable;
      oldMean = modelMean;
      expMean = refMeans(oldMean, enabled, accumolatorIn, countersIn, n);
      expLat  = 2 + T + 3 * DIV_W * n;
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput({tag, " busy in LOAD"}, MW'(busy), MW'(1));
      cycles = 0;
      stable = 1'b1;
      while (done !== 1'b1 && cycles < expLat + 20) begin
         tick();
         cycles++;
         if (done !== 1'b1 && meanOut !== oldMean) stable = 1'b0;
         if (chaos && cycles == 3) applyStimulus(1'b1);
         if (chaos && cycles == 5) begin
            randomSeed(junk);
            seedMean = junk;
            start    = 1'b1;
            seedLoad = 1'b1;
         end
         if (chaos && cycles == 6) begin
            start    = 1'b0;
            seedLoad = 1'b0;
         end
      end
      checkOutput({tag, " latency"}, MW'(cycles), MW'(expLat));
      checkOutput({tag, " meanOut"}, meanOut, expMean);
      checkOutput({tag, " converged"}, MW'(converged), MW'(expMean == oldMean));
      checkOutput({tag, " stable"}, MW'(stable), MW'(1));
      checkOutput({tag, " busy after"}, MW'(busy), '0);
      extraDone = 0;
      repeat (3) begin
         tick();
         if (done === 1'b1) extraDone++;
      end
      checkOutput({tag, " done once"}, MW'(extraDone), '0);
      modelMean = expMean;
   endtask

   initial begin
      logic [MW-1:0] seed;
      int busySeen;
      testsRun      = 0;
      failCount     = 0;
      modelMean     = '0;
      reset         = 1'b1;
      start         = 1'b0;
      seedLoad      = 1'b0;
      enabled       = '0;
      accumolatorIn = '0;
      countersIn    = '0;
      seedMean      = '0;

      // Reset state
      tick();
      tick();
      checkOutput("reset meanOut", meanOut, '0);
      checkOutput("reset busy", MW'(busy), '0);
      checkOutput("reset done", MW'(done), '0);
      checkOutput("reset converged", MW'(converged), '0);
      reset = 1'b0;
      tick();

      // Reset in the middle of a division discards the pass
      randomSeed(seed);
      loadSeed(seed);
      applyStimulus(1'b0);
      enabled[0] = 1'b1;
      countersIn[11:0] = 12'd7;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (40) tick();
      reset = 1'b1;
      #1;
      checkOutput("midreset meanOut", meanOut, '0);
      checkOutput("midreset busy", MW'(busy), '0);
      tick();
      reset = 1'b0;
      tick();
      checkOutput("midreset done", MW'(done), '0);
      checkOutput("midreset busy idle", MW'(busy), '0);
      modelMean = '0;
      applyStimulus(1'b0);
      runPass("after reset", 1'b0);

      // Seeded cluster with no pixels keeps its mean; nothing divides
      randomSeed(seed);
      seed[23:0] = 24'h112233;
      loadSeed(seed);
      enabled       = '1;
      countersIn    = '0;
      accumolatorIn = '0;
      runPass("no pixels", 1'b0);
      checkOutput("no pixels cluster0", MW'(meanOut[23:0]), MW'(24'h112233));
      checkOutput("no pixels converged", MW'(converged), MW'(1));

      // Single cluster, exact divisions
      enabled       = '0;
      enabled[0]    = 1'b1;
      countersIn[11:0] = 12'd3;
      accumolatorIn[23:0]  = 24'd300;
      accumolatorIn[47:24] = 24'd600;
      accumolatorIn[71:48] = 24'd153;
      runPass("cluster0", 1'b0);
      checkOutput("cluster0 value", MW'(meanOut[23:0]), MW'(24'h33C864));

      // Rounding and saturation corners
      enabled       = '0;
      enabled[2:0]  = 3'b111;
      countersIn    = '0;
      accumolatorIn = '0;
      countersIn[11:0]      = 12'd4;
      accumolatorIn[23:0]   = 24'd10;
      accumolatorIn[71:48]  = 24'd7;
      countersIn[23:12]     = 12'd4095;
      accumolatorIn[95:72]  = 24'd1044225;
      accumolatorIn[119:96] = 24'd1044225;
      accumolatorIn[143:120]= 24'd1044225;
      countersIn[35:24]     = 12'd1;
      accumolatorIn[167:144]= 24'd2000;
      accumolatorIn[191:168]= 24'd255;
      accumolatorIn[215:192]= 24'd256;
      runPass("corners", 1'b0);
`ifdef MEAN_ROUND_EN
      checkOutput("ten over four", MW'(meanOut[7:0]), MW'(3));
`else
      checkOutput("ten over four", MW'(meanOut[7:0]), MW'(2));
`endif
      checkOutput("full count", MW'(meanOut[31:24]), MW'(255));
      checkOutput("overflow sat", MW'(meanOut[55:48]), MW'(255));
      checkOutput("just over sat", MW'(meanOut[71:64]), MW'(255));

      // start/seedLoad while busy are ignored; inputs after LOAD ignored
      applyStimulus(1'b0);
      enabled[0] = 1'b1;
      countersIn[11:0] = 12'd9;
      runPass("busy ignore", 1'b1);

      // seedLoad together with start in IDLE: seed wins, no pass
      randomSeed(seed);
      seedMean = seed;
      seedLoad = 1'b1;
      start    = 1'b1;
      tick();
      seedLoad = 1'b0;
      start    = 1'b0;
      modelMean = seed;
      checkOutput("seed+start meanOut", meanOut, seed);
      checkOutput("seed+start converged", MW'(converged), '0);
      busySeen = 0;
      repeat (5) begin
         if (busy === 1'b1 || done === 1'b1) busySeen++;
         tick();
      end
      checkOutput("seed+start no pass", MW'(busySeen), '0);

      // Random passes, each repeated to confirm convergence detection
      for (int i = 0; i < 3; i++) begin
         applyStimulus(i == 2);
         runPass("random", 1'b0);
         runPass("repeat", 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule

// File: doc/mean_update_engine.md
Name: mean_update_engine

Overview:
- Downstream stage of cluster_engine: consumes its per-cluster channel sums (accumolator) and pixel counters at the end of an image pass, and computes the new cluster means by serial division.
- The new means are driven back onto cluster_engine's meanIn.
- Holds the live mean register set; flags convergence when an iteration produces no change.

Parameters:
- T, 16, number of clusters (matches cluster_engine T)
- DIV_W, 24, dividend width / divide iterations per channel

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- start  input  1  one-cycle pulse: snapshot inputs and begin an update pass
- enabled  input  T  cluster enable mask; bit k=0 means cluster k is skipped
- accumolatorIn  input  72*T  per cluster k at [k*72 +:72]; channel c (0..2) sum at [c*24 +:24]
- countersIn  input  12*T  per cluster k pixel count at [k*12 +:12]
- seedLoad  input  1  load initial means from seedMean
- seedMean  input  24*T  initial means; cluster k at [k*24 +:24]
- meanOut  output  24*T  current means; cluster k at [k*24 +:24], channel c byte at [k*24+c*8 +:8]
- busy  output  1  high from the LOAD cycle through the DONE cycle
- done  output  1  one-cycle pulse when meanOut has been updated
- converged  output  1  last pass left every mean unchanged

Behaviour:
- Reset: meanOut=0, busy=0, done=0, converged=0, FSM=IDLE. Reset mid-pass aborts the pass; no partial results are kept.
- FSM states:
  - IDLE: on seedLoad, meanOut<=seedMean and converged<=0. Otherwise, on start, go to LOAD. If seedLoad and start are high together, the seed wins and start is dropped.
  - LOAD (1 cycle): snapshot accumolatorIn, countersIn and enabled into internal registers; copy meanOut into working register newMean; k=0.
  - SELECT (1 cycle per cluster): if enabled[k]=0 or count[k]=0, newMean[k] keeps its old value and k advances (or go to DONE after k=T-1). Otherwise c=0 and go to DIV.
  - DIV (DIV_W cycles per channel): restoring division, one quotient bit per cycle, 24-bit dividend / 12-bit divisor. On the last iteration, write quotient into newMean[k][c*8 +:8]. If the quotient exceeds 255, saturate to 255. Then either c++ (stay in DIV), or after c=2 do k++ and go to SELECT, or after k=T-1 go to DONE.
  - DONE (1 cycle): meanOut<=newMean (atomic update); converged<=(newMean==meanOut over all T clusters); done=1; return to IDLE.
- Latency: with N = number of clusters that are enabled and have nonzero count, done asserts 2+T+3*DIV_W*N cycles after the start-sampling edge. Example: T=16, N=16 gives 1170.
- start or seedLoad while busy: ignored, no effect.
- Quotient is truncating (floor) unless the optional feature is enabled.
- Input changes after LOAD do not affect the pass.
- meanOut is stable throughout a pass.

Optional Feature:
- MEAN_ROUND_EN.
- Defined: dividend = sum + (count>>1), giving round-half-up means; saturation to 255 still applies.
- Undefined: dividend = sum, truncating division.
- Latency is identical in both builds.

Decomposition:
- Package kmeans_pkg holds:
  - constants PIX_W=24, CH_W=8, ACC_W=72, CNT_W=12, N_CH=3
  - state encoding typedef (IDLE, LOAD, SELECT, DIV, DONE)
- One natural sub-module, serial_divider: start/busy/valid, restoring, 24/12 bit, with quotient and remainder outputs. The FSM sequences it once per channel.

Test Plan:
- Reset mid-DIV (assert reset 40 cycles after start), then release -> meanOut=0, busy=0, done=0; a following start completes normally.
- seedLoad with cluster0=0x112233, then start with count0=0 and enabled=all ones -> cluster0 stays 0x112233 and converged=1 (T=16, no divisions: done 18 cycles after start).
- Cluster0 count=3, sums ch0=300, ch1=600, ch2=153; other clusters disabled -> meanOut[23:0]=0x33C864; done exactly 2+16+72=90 cycles after start; converged=0 if the seed differed.
- Cluster0 sum ch0=10, count=4 -> ch0 byte=2 without MEAN_ROUND_EN, 3 with it. Sum=1,044,225, count=4095 -> 255.
- Overflow case: sum=2000, count=1 -> byte saturates to 255.
- start pulsed again while busy, and seedLoad together with start in IDLE -> mid-pass start has no effect and done pulses once; seed loaded and no pass begins (busy stays 0).
